// File: rtl/key_note_encoder.sv
// Key-switch front end: synchronises and debounces a raw key vector and octave buttons,
// encodes the active key to a 1-based note index and emits held level plus press/release pulses.
module key_note_encoder #(
  parameter int NUM_KEYS        = 8,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int LAST_PRIORITY   = 0,
  parameter int OCT_W           = 2,
  parameter int OCT_RESET       = 1,
  parameter int OCT_MAX         = 3,
  localparam int KW             = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_on,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                oct_up,
  input  logic                oct_down,
  output logic [KW-1:0]       key_out,
  output logic                key_out_on,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [OCT_W-1:0]    octave
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [OCT_W-1:0] OCT_MAX_V = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] OCT_RST_V = OCT_W'(OCT_RESET);

  typedef enum logic {IDLE, HELD} state_t;

  logic [NUM_KEYS-1:0] keyS1_q, keyS2_q, keyPrev_q, keyDeb_q, keyDebPrev_q;
  logic [CW-1:0]       keyCnt_q, keyCnt_d;
  logic                keyLoad;

  logic [1:0]          octS1_q, octS2_q, octPrev_q, octDeb_q;
  logic [CW-1:0]       octCnt_q, octCnt_d;
  logic                octLoad;
  logic                upRise, dnRise;
  logic [OCT_W-1:0]    octave_q, octave_d;

  logic [NUM_KEYS-1:0] newlySet;
  logic                curHeld;
  logic [KW-1:0]       idx;

  state_t              state_q, state_d;
  logic [KW-1:0]       keyOut_q, keyOut_d;
  logic                press_q, press_d, release_q, release_d;

  function automatic logic [KW-1:0] lowestIdx(input logic [NUM_KEYS-1:0] v);
    lowestIdx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowestIdx = KW'(i + 1);
    end
  endfunction

  // The debounced vector loads on the same edge the counter reaches its final count.
  always_comb begin
    keyCnt_d = keyCnt_q;
    keyLoad  = 1'b0;
    if (keyS2_q != keyPrev_q) begin
      keyCnt_d = '0;
    end else begin
      if (keyCnt_q != CNT_MAX) keyCnt_d = keyCnt_q + CW'(1);
      keyLoad = (keyCnt_q == CNT_LOAD);
    end
  end

  always_comb begin
    octCnt_d = octCnt_q;
    octLoad  = 1'b0;
    if (octS2_q != octPrev_q) begin
      octCnt_d = '0;
    end else begin
      if (octCnt_q != CNT_MAX) octCnt_d = octCnt_q + CW'(1);
      octLoad = (octCnt_q == CNT_LOAD);
    end
  end

  always_comb begin
    upRise   = octLoad && octS2_q[0] && !octDeb_q[0];
    dnRise   = octLoad && octS2_q[1] && !octDeb_q[1];
    octave_d = octave_q;
    if (upRise && !dnRise && octave_q != OCT_MAX_V) begin
      octave_d = octave_q + OCT_W'(1);
    end else if (dnRise && !upRise && octave_q != '0) begin
      octave_d = octave_q - OCT_W'(1);
    end
  end

  // In last-pressed mode the current note survives unless a fresh key appears or it is let go.
  always_comb begin
    newlySet = keyDeb_q & ~keyDebPrev_q;
    curHeld  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keyOut_q == KW'(i + 1) && keyDeb_q[i]) curHeld = 1'b1;
    end
    if (LAST_PRIORITY == 0) begin
      idx = lowestIdx(keyDeb_q);
    end else if (newlySet != '0) begin
      idx = lowestIdx(newlySet);
    end else if (curHeld) begin
      idx = keyOut_q;
    end else begin
      idx = lowestIdx(keyDeb_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    keyOut_d  = keyOut_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        keyOut_d = '0;
        if (key_on && keyDeb_q != '0) begin
          state_d  = HELD;
          keyOut_d = idx;
          press_d  = 1'b1;
        end
      end
      HELD: begin
        if (!key_on || keyDeb_q == '0) begin
          state_d   = IDLE;
          keyOut_d  = '0;
          release_d = 1'b1;
        end else if (idx != keyOut_q) begin
          keyOut_d = idx;
          press_d  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        keyOut_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyS1_q      <= '0;
      keyS2_q      <= '0;
      keyPrev_q    <= '0;
      keyDeb_q     <= '0;
      keyDebPrev_q <= '0;
      keyCnt_q     <= '0;
      octS1_q      <= '0;
      octS2_q      <= '0;
      octPrev_q    <= '0;
      octDeb_q     <= '0;
      octCnt_q     <= '0;
      octave_q     <= OCT_RST_V;
      state_q      <= IDLE;
      keyOut_q     <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      keyS1_q      <= key;
      keyS2_q      <= keyS1_q;
      keyPrev_q    <= keyS2_q;
      keyCnt_q     <= keyCnt_d;
      if (keyLoad) keyDeb_q <= keyS2_q;
      keyDebPrev_q <= keyDeb_q;
      octS1_q      <= {oct_down, oct_up};
      octS2_q      <= octS1_q;
      octPrev_q    <= octS2_q;
      octCnt_q     <= octCnt_d;
      if (octLoad) octDeb_q <= octS2_q;
      octave_q     <= octave_d;
      state_q      <= state_d;
      keyOut_q     <= keyOut_d;
      press_q      <= press_d;
      release_q    <= release_d;
    end
  end

  assign key_out       = keyOut_q;
  assign key_out_on    = (state_q == HELD);
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign octave        = octave_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// Bench for key_note_encoder: two instances (lowest-index and last-pressed priority) share
// stimulus; directed steps plus random hold/glitch patterns are checked against a spec-level model.
module tb_key_note_encoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_on;
  logic [7:0] key;
  logic       oct_up, oct_down;

  logic [3:0] keyOut0, keyOut1;
  logic       on0, on1, press0, press1, rel0, rel1;
  logic [1:0] oct0, oct1;

  int nAsserts = 0;
  int nFails   = 0;

  int pressCnt0 = 0, pressCnt1 = 0, relCnt0 = 0, relCnt1 = 0;
  int overlapCnt = 0, longCnt = 0;
  logic prevP0 = 1'b0, prevP1 = 1'b0, prevR0 = 1'b0, prevR1 = 1'b0;

  logic [7:0] curPat;
  int note0, note1, expOct;

  always #5 clk = ~clk;

  key_note_encoder #(.NUM_KEYS(8), .DEBOUNCE_CYCLES(DB), .LAST_PRIORITY(0),
                     .OCT_W(2), .OCT_RESET(1), .OCT_MAX(3)) dut0 (
    .clk(clk), .rst(rst), .key_on(key_on), .key(key), .oct_up(oct_up), .oct_down(oct_down),
    .key_out(keyOut0), .key_out_on(on0), .press_pulse(press0), .release_pulse(rel0),
    .octave(oct0));

  key_note_encoder #(.NUM_KEYS(8), .DEBOUNCE_CYCLES(DB), .LAST_PRIORITY(1),
                     .OCT_W(2), .OCT_RESET(1), .OCT_MAX(3)) dut1 (
    .clk(clk), .rst(rst), .key_on(key_on), .key(key), .oct_up(oct_up), .oct_down(oct_down),
    .key_out(keyOut1), .key_out_on(on1), .press_pulse(press1), .release_pulse(rel1),
    .octave(oct1));

  // Pulse bookkeeping sampled mid-cycle; the main sequence compares count deltas per window.
  always @(negedge clk) begin
    if (press0) pressCnt0++;
    if (press1) pressCnt1++;
    if (rel0) relCnt0++;
    if (rel1) relCnt1++;
    if ((press0 && rel0) || (press1 && rel1)) overlapCnt++;
    if ((press0 && prevP0) || (press1 && prevP1) || (rel0 && prevR0) || (rel1 && prevR1)) longCnt++;
    prevP0 = press0;
    prevP1 = press1;
    prevR0 = rel0;
    prevR1 = rel1;
  end

  function automatic int lowestIdx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic int recentNote(input logic [7:0] prevPat, input logic [7:0] pat, input int cur);
    logic [7:0] fresh;
    fresh = pat & ~prevPat;
    if (fresh != 8'h00) return lowestIdx(fresh);
    if (cur != 0 && pat[cur-1]) return cur;
    return lowestIdx(pat);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic on, input logic [7:0] k, input logic up, input logic dn);
    key_on   = on;
    key      = k;
    oct_up   = up;
    oct_down = dn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic holdPattern(input logic [7:0] pat, input string tag);
    int n0, n1, p0, p1, r0, r1;
    n0 = lowestIdx(pat);
    n1 = recentNote(curPat, pat, note1);
    p0 = pressCnt0; p1 = pressCnt1; r0 = relCnt0; r1 = relCnt1;
    applyStimulus(1'b1, pat, 1'b0, 1'b0);
    waitCycles(DB + 6);
    checkOutput({tag, "_note0"}, 32'(keyOut0), 32'(n0));
    checkOutput({tag, "_note1"}, 32'(keyOut1), 32'(n1));
    checkOutput({tag, "_on0"}, 32'(on0), 32'(n0 != 0));
    checkOutput({tag, "_press0"}, 32'(pressCnt0 - p0), 32'(n0 != 0 && n0 != note0));
    checkOutput({tag, "_rel0"}, 32'(relCnt0 - r0), 32'(note0 != 0 && n0 == 0));
    checkOutput({tag, "_press1"}, 32'(pressCnt1 - p1), 32'(n1 != 0 && n1 != note1));
    checkOutput({tag, "_rel1"}, 32'(relCnt1 - r1), 32'(note1 != 0 && n1 == 0));
    curPat = pat;
    note0  = n0;
    note1  = n1;
  endtask

  task automatic glitch(input logic [7:0] pat, input int len);
    int p, r;
    p = pressCnt0 + pressCnt1;
    r = relCnt0 + relCnt1;
    applyStimulus(1'b1, pat, 1'b0, 1'b0);
    waitCycles(len);
    applyStimulus(1'b1, curPat, 1'b0, 1'b0);
    waitCycles(DB + 6);
    checkOutput("glitch_note0", 32'(keyOut0), 32'(note0));
    checkOutput("glitch_note1", 32'(keyOut1), 32'(note1));
    checkOutput("glitch_pulses", 32'(pressCnt0 + pressCnt1 + relCnt0 + relCnt1 - p - r), 32'(0));
  endtask

  task automatic octPress(input logic up, input logic dn);
    applyStimulus(1'b1, 8'h00, up, dn);
    waitCycles(DB + 4);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    waitCycles(DB + 4);
    if (up && !dn) expOct = (expOct < 3) ? expOct + 1 : 3;
    else if (dn && !up) expOct = (expOct > 0) ? expOct - 1 : 0;
    checkOutput("octave0", 32'(oct0), 32'(expOct));
    checkOutput("octave1", 32'(oct1), 32'(expOct));
  endtask

  initial begin
    int p, r;
    logic [7:0] pat;
    rst = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    curPat = 8'h00; note0 = 0; note1 = 0; expOct = 1;
    waitCycles(2);
    checkOutput("rst_key_out", 32'(keyOut0), 32'(0));
    checkOutput("rst_on", 32'(on0), 32'(0));
    checkOutput("rst_pulses", 32'({press0, rel0, press1, rel1}), 32'(0));
    checkOutput("rst_octave", 32'(oct0), 32'(1));
    rst = 1'b0;
    waitCycles(DB + 6);

    // Exact latency of DEBOUNCE_CYCLES+3 edges for press and release.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    waitCycles(DB + 2);
    checkOutput("lat_before", 32'(keyOut0), 32'(0));
    waitCycles(1);
    checkOutput("lat_note", 32'(keyOut0), 32'(1));
    checkOutput("lat_on", 32'(on0), 32'(1));
    checkOutput("lat_press", 32'(press0), 32'(1));
    waitCycles(1);
    checkOutput("lat_press_end", 32'(press0), 32'(0));
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    waitCycles(DB + 2);
    checkOutput("rel_before", 32'(keyOut0), 32'(1));
    waitCycles(1);
    checkOutput("rel_note", 32'(keyOut0), 32'(0));
    checkOutput("rel_pulse", 32'(rel0), 32'(1));
    waitCycles(1);
    checkOutput("rel_pulse_end", 32'(rel0), 32'(0));

    glitch(8'h04, 2);

    holdPattern(8'h08, "A");
    holdPattern(8'h0A, "B");
    checkOutput("B_const0", 32'(keyOut0), 32'(2));
    holdPattern(8'h00, "C");
    holdPattern(8'h02, "D");
    holdPattern(8'h0A, "E");
    checkOutput("E_const1", 32'(keyOut1), 32'(4));
    holdPattern(8'h02, "F");
    checkOutput("F_const1", 32'(keyOut1), 32'(2));
    holdPattern(8'h00, "G");

    p = pressCnt0 + pressCnt1;
    r = relCnt0 + relCnt1;
    repeat (3) octPress(1'b1, 1'b0);
    repeat (4) octPress(1'b0, 1'b1);
    octPress(1'b1, 1'b0);
    octPress(1'b1, 1'b1);
    checkOutput("oct_no_pulses", 32'(pressCnt0 + pressCnt1 + relCnt0 + relCnt1 - p - r), 32'(0));
    checkOutput("oct_key_out", 32'(keyOut0), 32'(0));

    // Asynchronous reset while a note is held.
    holdPattern(8'h04, "R");
    p = pressCnt0;
    r = relCnt0 + relCnt1;
    rst = 1'b1;
    #1;
    checkOutput("arst_key_out", 32'({keyOut0, keyOut1}), 32'(0));
    checkOutput("arst_on", 32'({on0, on1}), 32'(0));
    checkOutput("arst_octave", 32'(oct0), 32'(1));
    #19;
    rst = 1'b0;
    expOct = 1;
    waitCycles(DB + 2);
    checkOutput("arst_before", 32'(keyOut0), 32'(0));
    waitCycles(1);
    checkOutput("arst_note0", 32'(keyOut0), 32'(3));
    checkOutput("arst_note1", 32'(keyOut1), 32'(3));
    waitCycles(1);
    checkOutput("arst_press", 32'(pressCnt0 - p), 32'(1));
    checkOutput("arst_no_release", 32'(relCnt0 + relCnt1 - r), 32'(0));
    checkOutput("arst_octave_after", 32'(oct0), 32'(1));

    // Keyboard enable gating.
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b0);
    waitCycles(DB + 6);
    checkOutput("keyon_off_note", 32'(keyOut0), 32'(0));
    checkOutput("keyon_off_on", 32'(on0), 32'(0));
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("keyon_note0", 32'(keyOut0), 32'(5));
    checkOutput("keyon_note1", 32'(keyOut1), 32'(5));
    checkOutput("keyon_press", 32'(press0), 32'(1));
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("keyoff_release", 32'(rel0), 32'(1));
    checkOutput("keyoff_note", 32'(keyOut0), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    waitCycles(DB + 6);
    curPat = 8'h00; note0 = 0; note1 = 0;

    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 2) == 0) glitch(curPat ^ 8'($urandom_range(1, 255)), $urandom_range(1, DB - 1));
      pat = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      holdPattern(pat, "rnd");
    end

    checkOutput("pulse_overlap", 32'(overlapCnt), 32'(0));
    checkOutput("pulse_width", 32'(longCnt), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/key_note_encoder.md
Name: key_note_encoder

Overview:
- Parametrised successor to the piano key controller.
- Synchronises and debounces a raw key-switch vector, then encodes the active key to a 1-based note index using a selectable priority rule.
- Tracks a saturating octave register driven by debounced up/down buttons.
- Emits held-note level and press/release event pulses to the tone generator.

Parameters:
NUM_KEYS, 8, number of key switches (2..15)
DEBOUNCE_CYCLES, 200000, consecutive stable cycles required to accept a new input vector (>=2)
LAST_PRIORITY, 0, 0 = lowest-index held key wins; 1 = most recently pressed key wins
OCT_W, 2, octave register width
OCT_RESET, 1, octave value after reset
OCT_MAX, 3, highest octave (<= 2^OCT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key_on  in  1  keyboard enable level (synchronous)
key  in  NUM_KEYS  raw switches, 1 = pressed, asynchronous
oct_up  in  1  raw octave-up button, asynchronous
oct_down  in  1  raw octave-down button, asynchronous
key_out  out  KW=$clog2(NUM_KEYS+1)  note index, bit i -> i+1, 0 = none
key_out_on  out  1  note held
press_pulse  out  1  one-cycle pulse on new/changed note
release_pulse  out  1  one-cycle pulse on note end
octave  out  OCT_W  current octave

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high.
- Reset values: all outputs 0 except octave = OCT_RESET. Sync flops, debounce counters and debounced vectors are all 0.
- Reset mid-hold clears immediately with no release_pulse.
- Sync: every raw input passes a 2-flop synchroniser.
- Key debounce (shared counter over the whole synced key vector):
  - Counter clears whenever the synced vector differs from its previous-cycle value; otherwise it increments, saturating.
  - Debounced vector loads when the counter reaches DEBOUNCE_CYCLES-1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are never accepted.
- Latency: raw key change to key_out/press_pulse update = exactly DEBOUNCE_CYCLES+3 clk edges.
- Octave buttons: separate shared debounce counter, identical rule.
  - A rising edge of debounced oct_up increments octave, saturating at OCT_MAX.
  - A rising edge of debounced oct_down decrements, saturating at 0.
  - Both edges in the same cycle: no change.
  - Octave changes never produce press/release pulses and never alter key_out.
- Priority encoding (combinational on the debounced vector D):
  - LAST_PRIORITY=0: lowest set bit of D.
  - LAST_PRIORITY=1:
    - If D has bits newly set versus the previous D, select the lowest newly set bit.
    - Else if the current note is still held, keep it.
    - Else select the lowest set bit of D.
- FSM (registered outputs):
  - IDLE: key_out=0, key_out_on=0.
    - If key_on && D!=0: go to HELD, load key_out=idx, assert press_pulse.
  - HELD: key_out_on=1.
    - If !key_on or D==0: go to IDLE, key_out=0, assert release_pulse.
    - Else if idx != key_out: load idx, assert press_pulse (retrigger), no release_pulse.
    - Else hold.
- key_on deassert while held: release on the next edge. Debounce keeps running.
- key_on reassert with keys already debounced-held: press on the next edge.
- press_pulse and release_pulse are never high in the same cycle. Each lasts exactly 1 cycle.
- No latching: key_out always reflects current D under the priority rule.

Test Plan:
(Bench parameters: NUM_KEYS=8, DEBOUNCE_CYCLES=4, OCT_RESET=1, OCT_MAX=3; LAST_PRIORITY=0 unless stated.)
- Reset then key=8'h01 held, key_on=1 -> 7 edges later key_out=1, key_out_on=1, press_pulse for 1 cycle. key=0 -> 7 edges later key_out=0, release_pulse for 1 cycle.
- key=8'h04 for 2 cycles then 0 -> no output change, no pulses.
- Hold 8'h08 then add 8'h02 -> key_out 4 then 2, press_pulse twice, no release between.
  - With LAST_PRIORITY=1, hold 8'h02 then add 8'h08 -> key_out 2 then 4; release 8'h08 -> key_out returns to 2 with press_pulse.
- Octave: 3 oct_up presses -> octave 2, 3, 3 (saturated). 4 oct_down presses -> 2, 1, 0, 0. Simultaneous up/down press -> unchanged. No pulses throughout.
- key=8'h04 held, key_out=3; assert rst for 20 ns -> all outputs 0 and octave=1 immediately, no release_pulse. Release rst with key still held -> key_out=3 after DEBOUNCE_CYCLES+3 edges.
- key_on=0 with key=8'h10 held -> key_out stays 0. key_on=1 -> next edge key_out=5 with press_pulse. key_on=0 -> next edge release_pulse.
